// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC CPU: opcodes, IR field layout, and the
// control sequencer's state and instruction-class types.
package cpu_pkg;

    // 5-bit opcodes carried in IR[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // IR field bit positions
    localparam int unsigned IR_OP_MSB = 31;
    localparam int unsigned IR_OP_LSB = 27;
    localparam int unsigned IR_RA_MSB = 26;
    localparam int unsigned IR_RA_LSB = 23;
    localparam int unsigned IR_RB_MSB = 22;
    localparam int unsigned IR_RB_LSB = 19;
    localparam int unsigned IR_RC_MSB = 18;
    localparam int unsigned IR_RC_LSB = 15;
    localparam int unsigned IR_C_MSB  = 18;
    localparam int unsigned IR_C_LSB  = 0;

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
        ST_HALTED
    } state_t;

    typedef enum logic [3:0] {
        CL_REG,
        CL_IMM,
        CL_UNARY,
        CL_MULDIV,
        CL_LD,
        CL_ST,
        CL_MFHI,
        CL_MFLO,
        CL_NOP,
        CL_HALT,
        CL_ILLEGAL
    } iclass_t;

    // Groups opcodes by the execute sequence they share
    function automatic iclass_t decode_class(input logic [4:0] op);
        iclass_t c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:      c = CL_REG;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:     c = CL_IMM;
            OP_NEG, OP_NOT:                       c = CL_UNARY;
            OP_MUL, OP_DIV:                       c = CL_MULDIV;
            OP_LD:                                c = CL_LD;
            OP_ST:                                c = CL_ST;
            OP_MFHI:                              c = CL_MFHI;
            OP_MFLO:                              c = CL_MFLO;
            OP_NOP:                               c = CL_NOP;
            OP_HALT:                              c = CL_HALT;
            OP_BR, OP_JR, OP_JAL, OP_IN, OP_OUT:  c = CL_ILLEGAL;
            default:                              c = CL_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch (T0-T2) then a per-class execute
// sequence (T3-T7), stalling on mem_done and parking in HALTED on halt.
module control_unit
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_done,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        BAout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        ZHighIn,
    output logic        ZLowIn,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  opcode,
    output logic        running,
    output logic        illegal
);

    state_t     state;
    logic       fresh;
    logic [4:0] ir_op;
    iclass_t    iclass;
    logic       unused_ir_fields;

    assign ir_op  = ir[IR_OP_MSB:IR_OP_LSB];
    assign iclass = decode_class(ir_op);

    // Register fields are consumed by the datapath's select-and-encode logic
    assign unused_ir_fields = ^{ir[IR_RA_MSB:IR_RA_LSB], ir[IR_RB_MSB:IR_RB_LSB],
                                ir[IR_RC_MSB:IR_RC_LSB], ir[IR_C_MSB:IR_C_LSB]};

    // State sequencing; fresh marks the first cycle spent in a state.
    // RST is entered with fresh set so that it lingers for one extra edge,
    // putting the first T0 on the second edge after clear is released.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= ST_RST;
            fresh <= 1'b1;
        end else begin
            fresh <= 1'b1;
            case (state)
                ST_RST: begin
                    if (fresh) fresh <= 1'b0;
                    else       state <= ST_T0;
                end
                ST_T0: state <= ST_T1;
                ST_T1: begin
                    if (mem_done) state <= ST_T2;
                    else          fresh <= 1'b0;
                end
                ST_T2: state <= ST_T3;
                ST_T3: begin
                    case (iclass)
                        CL_REG, CL_IMM, CL_UNARY,
                        CL_MULDIV, CL_LD, CL_ST:   state <= ST_T4;
                        CL_HALT:                   state <= ST_HALTED;
                        default:                   state <= ST_T0;
                    endcase
                end
                ST_T4: state <= (iclass == CL_UNARY) ? ST_T0 : ST_T5;
                ST_T5: state <= (iclass == CL_REG || iclass == CL_IMM) ? ST_T0 : ST_T6;
                ST_T6: begin
                    case (iclass)
                        CL_LD: begin
                            if (mem_done) state <= ST_T7;
                            else          fresh <= 1'b0;
                        end
                        CL_ST:   state <= ST_T7;
                        default: state <= ST_T0;
                    endcase
                end
                ST_T7: begin
                    if (iclass == CL_ST && !mem_done) fresh <= 1'b0;
                    else                              state <= ST_T0;
                end
                ST_HALTED: fresh <= 1'b0;
                default:   state <= ST_RST;
            endcase
        end
    end

    // Moore decode of control strobes from the state and the latched IR
    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        Cout     = 1'b0;
        BAout    = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        ZHighIn  = 1'b0;
        ZLowIn   = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        opcode   = '0;
        running  = 1'b1;
        illegal  = 1'b0;
        case (state)
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
            end
            ST_T1: begin
                // PC load only on entry, so a stalled read does not repeat it
                Zlowout = 1'b1; PCin = fresh; Read = 1'b1; MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                case (iclass)
                    CL_REG, CL_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_UNARY: begin
                        Grb = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; opcode = ir_op;
                    end
                    CL_MULDIV:   begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_LD, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    CL_MFHI:     begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_MFLO:     begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_ILLEGAL:  illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (iclass)
                    CL_REG: begin
                        Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; opcode = ir_op;
                    end
                    CL_IMM: begin
                        Cout = 1'b1; ZLowIn = 1'b1;
                        opcode = (ir_op == OP_LDI) ? OP_ADD : ir_op;
                    end
                    CL_UNARY: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_MULDIV: begin
                        Grb = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1;
                        opcode = ir_op;
                    end
                    CL_LD, CL_ST: begin Cout = 1'b1; ZLowIn = 1'b1; opcode = OP_ADD; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (iclass)
                    CL_REG, CL_IMM: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_MULDIV:      begin Zlowout = 1'b1; LOin = 1'b1; end
                    CL_LD, CL_ST:   begin Zlowout = 1'b1; MARin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (iclass)
                    CL_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                    CL_LD:     begin Read = 1'b1; MDRin = 1'b1; end
                    CL_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (iclass)
                    CL_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_ST:   Write = 1'b1;
                    default: ;
                endcase
            end
            ST_HALTED: running = 1'b0;
            default: ;
        endcase
    end

endmodule
